// File: rtl/score_collector_pkg.sv
`default_nettype none
// ============================================================================
// Module      : score_collector_pkg
// Description : Shared frame sizes and FSM state encoding for the output layer.
// Revision    : 1.0 - initial release
// ============================================================================
package score_collector_pkg;

    localparam int c_N_SCORES = 10;
    localparam int c_DATA_W   = 8;
    localparam int c_IDX_W    = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/score_collector_max_tracker.sv
`default_nettype none
// ============================================================================
// Module      : max_tracker
// Description : Running maximum and its index; strict compare keeps lowest index.
// Revision    : 1.0 - initial release
// ============================================================================
module max_tracker
    import score_collector_pkg::*;
#(
    parameter int DATA_W = c_DATA_W,
    parameter int IDX_W  = c_IDX_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              enable,
    input  logic [DATA_W-1:0] data,
    input  logic [IDX_W-1:0]  index,
    output logic [DATA_W-1:0] max_val,
    output logic [IDX_W-1:0]  argmax
);

    logic [DATA_W-1:0] r_max;
    logic [IDX_W-1:0]  r_arg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_max <= '0;
            r_arg <= '0;
        end else if (clear) begin
            r_max <= '0;
            r_arg <= '0;
        end else if (enable && (data > r_max)) begin
            r_max <= data;
            r_arg <= index;
        end
    end

    assign max_val = r_max;
    assign argmax  = r_arg;

endmodule
`default_nettype wire

// File: rtl/score_collector.sv
`default_nettype none
// ============================================================================
// Module      : score_collector
// Description : Buffers one frame of output-layer scores and tracks the argmax.
// Revision    : 1.0 - initial release
// ============================================================================
module score_collector
    import score_collector_pkg::*;
#(
    parameter int N_SCORES = c_N_SCORES,
    parameter int DATA_W   = c_DATA_W,
    parameter int IDX_W    = c_IDX_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       in_valid,
    input  logic [DATA_W-1:0]          in_data,
    output logic                       in_ready,
    output logic [N_SCORES*DATA_W-1:0] scores,
    output logic [DATA_W-1:0]          max_val,
    output logic [IDX_W-1:0]           argmax,
    output logic                       busy,
    output logic                       done,
    input  logic                       done_ack
);

    state_t           r_state;
    logic [IDX_W-1:0] r_count;
    logic             r_in_ready;
    logic             r_busy;
    logic             r_done;

    logic w_xfer;
    logic w_last;
    logic w_clear;

    assign w_xfer  = in_valid & r_in_ready;
    assign w_last  = (r_count == IDX_W'(N_SCORES - 1));
    // A start outside COLLECT (IDLE, or DONE acting as ack) opens a fresh frame
    assign w_clear = start & (r_state != ST_COLLECT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_count    <= '0;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state    <= ST_COLLECT;
                        r_count    <= '0;
                        r_in_ready <= 1'b1;
                        r_busy     <= 1'b1;
                    end
                end
                ST_COLLECT: begin
                    if (w_xfer) begin
                        if (w_last) begin
                            // count parks on the last slot so it never passes N_SCORES-1
                            r_state    <= ST_DONE;
                            r_in_ready <= 1'b0;
                            r_busy     <= 1'b0;
                            r_done     <= 1'b1;
                        end else begin
                            r_count <= r_count + 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    if (start) begin
                        r_state    <= ST_COLLECT;
                        r_count    <= '0;
                        r_in_ready <= 1'b1;
                        r_busy     <= 1'b1;
                        r_done     <= 1'b0;
                    end else if (done_ack) begin
                        r_state <= ST_IDLE;
                        r_done  <= 1'b0;
                    end
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_count    <= '0;
                    r_in_ready <= 1'b0;
                    r_busy     <= 1'b0;
                    r_done     <= 1'b0;
                end
            endcase
        end
    end

    for (genvar k = 0; k < N_SCORES; k++) begin : g_slot
        logic [DATA_W-1:0] r_slot;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_slot <= '0;
            end else if (w_clear) begin
                r_slot <= '0;
            end else if (w_xfer && (r_count == IDX_W'(k))) begin
                r_slot <= in_data;
            end
        end

        assign scores[k*DATA_W +: DATA_W] = r_slot;
    end

    max_tracker #(
        .DATA_W (DATA_W),
        .IDX_W  (IDX_W)
    ) u_max_tracker (
        .clk     (clk),
        .rst     (rst),
        .clear   (w_clear),
        .enable  (w_xfer),
        .data    (in_data),
        .index   (r_count),
        .max_val (max_val),
        .argmax  (argmax)
    );

    assign in_ready = r_in_ready;
    assign busy     = r_busy;
    assign done     = r_done;

endmodule
`default_nettype wire

// File: tb/tb_score_collector.sv
`default_nettype none
// ============================================================================
// Module      : tb_score_collector
// Description : Scoreboard bench for score_collector against a frame-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_score_collector;

    localparam int N = 10;
    localparam int W = 8;
    localparam int I = 4;

    typedef logic [W-1:0] frame_t [N];
    typedef struct {
        logic [N*W-1:0] sc;
        logic [W-1:0]   mx;
        logic [I-1:0]   am;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           start = 1'b0;
    logic           in_valid = 1'b0;
    logic [W-1:0]   in_data = '0;
    logic           in_ready;
    logic [N*W-1:0] scores;
    logic [W-1:0]   max_val;
    logic [I-1:0]   argmax;
    logic           busy;
    logic           done;
    logic           done_ack = 1'b0;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    logic done_q   = 1'b0;
    exp_t sb_q[$];

    score_collector dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .scores   (scores),
        .max_val  (max_val),
        .argmax   (argmax),
        .busy     (busy),
        .done     (done),
        .done_ack (done_ack)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [N*W-1:0] act, input logic [N*W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference: the frame maximum, then the first position holding it
    function automatic exp_t model(input frame_t v);
        exp_t e;
        bit   found;
        e.sc  = '0;
        e.mx  = '0;
        e.am  = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            e.sc[k*W +: W] = v[k];
            if (v[k] > e.mx) e.mx = v[k];
        end
        for (int k = 0; k < N; k++) begin
            if (!found && v[k] == e.mx) begin
                e.am  = I'(k);
                found = 1'b1;
            end
        end
        return e;
    endfunction

    // Monitor: each new done presentation consumes one expected frame
    always @(negedge clk) begin
        if (done && !done_q) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_done", 1'b1, 1'b0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("mon_scores", scores, e.sc);
                chk("mon_max_val", max_val, e.mx);
                chk("mon_argmax", argmax, e.am);
            end
        end
        done_q = done;
    end

    // mode 0: back-to-back, 1: valid toggling, 2: random gaps
    task automatic run_frame(input frame_t v, input int mode, input bit ack);
        exp_t e;
        int   idx, gaps, t, w, s;
        bit   rdy_seen;
        e = model(v);
        sb_q.push_back(e);
        idx = 0; gaps = 0; t = 0; rdy_seen = 1'b0;
        @(negedge clk);
        start = 1'b1; in_valid = 1'b0;
        s = cyc + 1;
        while (idx < N && t < 400) begin
            @(negedge clk);
            start = 1'b0;
            t++;
            if (in_valid && rdy_seen) idx++;
            if (idx < N) begin
                case (mode)
                    0:       in_valid = 1'b1;
                    1:       in_valid = t[0];
                    default: in_valid = ($urandom_range(0, 2) != 0);
                endcase
                if (!in_valid) gaps++;
                in_data  = v[idx];
                rdy_seen = in_ready;
            end else begin
                in_valid = 1'b0;
            end
        end
        if (idx < N) chk("frame_timeout", 1'b1, 1'b0);
        w = 0;
        while (!done && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk("done_seen", done, 1'b1);
        chk("latency", cyc - s + 1, N + 1 + gaps);
        repeat (2) begin
            chk("done_in_ready", in_ready, 1'b0);
            chk("done_busy", busy, 1'b0);
            in_valid = 1'b1;
            in_data  = W'($urandom);
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("done_hold", done, 1'b1);
        chk("done_hold_scores", scores, e.sc);
        chk("done_hold_max", max_val, e.mx);
        if (ack) begin
            done_ack = 1'b1;
            @(negedge clk);
            done_ack = 1'b0;
            chk("idle_done", done, 1'b0);
            chk("idle_busy", busy, 1'b0);
            chk("idle_scores", scores, e.sc);
            chk("idle_max", max_val, e.mx);
            chk("idle_argmax", argmax, e.am);
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_scores"}, scores, '0);
        chk({tag, "_max"}, max_val, '0);
        chk({tag, "_argmax"}, argmax, '0);
        chk({tag, "_in_ready"}, in_ready, 1'b0);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_done"}, done, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, n_fail=%0d expected 0", n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        frame_t f;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        f = '{8'd0, 8'd0, 8'd0, 8'd5, 8'd0, 8'd0, 8'd0, 8'd0, 8'd10, 8'd0};
        run_frame(f, 0, 1'b1);
        chk("slot3", scores[3*W +: W], 8'd5);

        f = '{default: 8'd0};
        run_frame(f, 0, 1'b1);

        f = '{8'd7, 8'd9, 8'd9, 8'd3, 8'd2, 8'd8, 8'd0, 8'd1, 8'd5, 8'd4};
        run_frame(f, 0, 1'b1);

        f = '{8'd0, 8'd0, 8'd0, 8'd5, 8'd0, 8'd0, 8'd0, 8'd0, 8'd10, 8'd0};
        run_frame(f, 1, 1'b1);

        // Abort a frame after four scores
        @(negedge clk);
        start = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            start    = 1'b0;
            in_valid = 1'b1;
            in_data  = W'(k + 20);
        end
        @(negedge clk);
        in_valid = 1'b0;
        chk("pre_rst_busy", busy, 1'b1);
        rst = 1'b1;
        #1;
        check_all_zero("async_rst");
        @(negedge clk);
        rst = 1'b0;
        repeat (3) begin
            in_valid = 1'b1;
            in_data  = 8'hAA;
            @(negedge clk);
            check_all_zero("no_start");
        end
        in_valid = 1'b0;

        // Leave a frame in DONE, then restart straight from there
        for (int k = 0; k < N; k++) f[k] = W'($urandom);
        run_frame(f, 0, 1'b0);
        for (int k = 0; k < N - 1; k++) f[k] = W'($urandom_range(0, 254));
        f[N-1] = 8'd255;
        run_frame(f, 0, 1'b1);

        for (int i = 0; i < 10; i++) begin
            for (int k = 0; k < N; k++)
                f[k] = W'($urandom_range(0, (i % 2 == 1) ? 3 : 255));
            run_frame(f, 2, (i % 3 != 0) || (i == 9));
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
